exunit_mul_pipe: RTL
====================

# exunit_mul_pipe

Pipelined integer multiply execution unit, directly downstream of the multiply reservation station. Accepts one issued MUL/MULH/MULHSU/MULHU operation per cycle with its operands, destination tag and speculation state. Delivers the 32-bit result plus destination tag to the result bus after a fixed latency. Squashes in-flight operations on branch misprediction and clears speculative bits on branch success.

## Interface
- `DATA_LEN`, 32: operand/result width.
- `RRF_SEL`, 6: rename-register tag width.
- `SPECTAG_LEN`, 5: speculation tag width (one-hot branch tag).

- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `issue` in 1: valid operation presented this cycle.
- `src1`, `src2` in DATA_LEN: operands.
- `src1_signed`, `src2_signed` in 1: operand signedness.
- `sel_lohi` in 1: 0 = low product half, 1 = high half.
- `rrftag` in RRF_SEL: destination tag.
- `dstval` in 1: destination write required.
- `spectag` in SPECTAG_LEN: branch dependency tag.
- `specbit` in 1: operation is speculative.
- `prmiss`, `prsuccess` in 1: branch resolved mispredicted / correct.
- `prtag` in SPECTAG_LEN: resolved branch tag (success).
- `specfixtag` in SPECTAG_LEN: tags invalidated by mispredict.
- `rslt_valid` out 1: result present this cycle.
- `rslt` out DATA_LEN: result.
- `rslt_dst` out RRF_SEL: destination tag.
- `rslt_we` out 1: `rslt_valid & dstval` of the result op.
- `kill_spec` out 1: result op is squashed this cycle; consumers discard it.
- `rslt_specbit` out 1: result op still speculative.
- `busy` out 1: any stage holds a valid op.

## Operation
- Stage S1: register extended operands (33 bits; bit 32 = sign bit if signed else 0), tag, dstval, sel_lohi, spectag, specbit, valid.
- Stage S2: partial products: P0 = ext1 × src2[15:0] (unsigned), P1 = ext1 × ext2[32:16] (signed 17-bit); registered.
- Stage S3: product = P0 + (P1 << 16), 66-bit two's complement; rslt = sel_lohi ? product[63:32] : product[31:0]; registered.
- Per-stage metadata travels with valid; no stall, no backpressure; new op accepted every cycle.
- prmiss: every stage (and incoming issue) with `(spectag & specfixtag) != 0` has valid cleared at next edge; `kill_spec` asserts combinationally in the same cycle if the output op matches.
- prsuccess: every stage (and incoming issue) with `spectag == prtag` has specbit cleared at next edge; `rslt_specbit` reflects the cleared value combinationally in that cycle.
- prmiss and prsuccess together: prmiss only; prsuccess ignored.
- Non-speculative ops (specbit=0) are never killed.
- `busy` = OR of stage valids.

## Timing
- Reset: all valids, specbits, tags, data cleared; every output 0 the cycle after reset_n sampled low. Reset mid-flight discards all ops, no result emitted.
- Latency: issue in cycle t → `rslt_valid` in cycle t+3 (t+4 with output register option).
- Throughput: 1 op/cycle; back-to-back issues emerge back-to-back in order.
- Killed op: valid dropped; produces no `rslt_valid` in later cycles.
- Kill/success check on the issue cycle itself applies to the incoming op.

## Configuration
- `MUL_OUT_REG_EN`: defined → extra output register after S3; latency 4; all outputs except `kill_spec`/`rslt_specbit` combinational flush terms are registered; prmiss/prsuccess checks also apply to output register. Undefined → outputs driven from S3, latency 3.

## Test plan
- Reset: hold reset_n=0 with issue=1 → rslt_valid=0, rslt=0, busy=0; release, no stale result appears.
- Arithmetic: src1=7, src2=0xFFFFFFFD signed/signed lo → 0xFFFFFFEB; 0x80000000×0x80000000 signed hi → 0x40000000; 0xFFFFFFFF×0xFFFFFFFF unsigned hi → 0xFFFFFFFE; src1=0xFFFFFFFF signed × src2=0xFFFFFFFF unsigned hi → 0xFFFFFFFF, each at t+3.
- Throughput: 4 back-to-back issues tags 1..4 → results in cycles t+3..t+6, tags 1..4 in order.
- Mispredict: ops spectag 0b00010 and 0b00100 in flight, prmiss with specfixtag=0b00010 → first never produces rslt_valid, second emerges normally; op at output during prmiss shows kill_spec=1.
- Branch success: specbit=1 spectag=0b01000 in S2, prsuccess prtag=0b01000 → rslt_specbit=0 at output; simultaneous prmiss overrides success.
- Config: MUL_OUT_REG_EN defined → same vectors emerge at t+4.

Source files
------------

// File: rtl/exunit_mul_pipe_if.sv
// exunit_mul_pipe_if
//   Issue bus, branch-resolution bus and result bus of the pipelined
//   multiply unit.
//   master : the reservation station / branch unit side. It drives the
//            issued op and the branch resolution, and receives the result.
//   slave  : the multiply unit itself.
//   Issue   : issue, src1, src2, src1_signed, src2_signed, sel_lohi,
//             rrftag, dstval, spectag, specbit
//   Branch  : prmiss, prsuccess, prtag, specfixtag
//   Result  : rslt_valid, rslt, rslt_dst, rslt_we, kill_spec,
//             rslt_specbit, busy
interface exunit_mul_pipe_if #(
  parameter int DATA_LEN    = 32,
  parameter int RRF_SEL     = 6,
  parameter int SPECTAG_LEN = 5
);
  logic                   issue;
  logic [DATA_LEN-1:0]    src1;
  logic [DATA_LEN-1:0]    src2;
  logic                   src1_signed;
  logic                   src2_signed;
  logic                   sel_lohi;
  logic [RRF_SEL-1:0]     rrftag;
  logic                   dstval;
  logic [SPECTAG_LEN-1:0] spectag;
  logic                   specbit;
  logic                   prmiss;
  logic                   prsuccess;
  logic [SPECTAG_LEN-1:0] prtag;
  logic [SPECTAG_LEN-1:0] specfixtag;
  logic                   rslt_valid;
  logic [DATA_LEN-1:0]    rslt;
  logic [RRF_SEL-1:0]     rslt_dst;
  logic                   rslt_we;
  logic                   kill_spec;
  logic                   rslt_specbit;
  logic                   busy;

  modport master (
    output issue, src1, src2, src1_signed, src2_signed, sel_lohi, rrftag,
           dstval, spectag, specbit, prmiss, prsuccess, prtag, specfixtag,
    input  rslt_valid, rslt, rslt_dst, rslt_we, kill_spec, rslt_specbit, busy
  );

  modport slave (
    input  issue, src1, src2, src1_signed, src2_signed, sel_lohi, rrftag,
           dstval, spectag, specbit, prmiss, prsuccess, prtag, specfixtag,
    output rslt_valid, rslt, rslt_dst, rslt_we, kill_spec, rslt_specbit, busy
  );
endinterface

// File: rtl/exunit_mul_pipe.sv
// exunit_mul_pipe
//   Pipelined 32x32 integer multiply (MUL/MULH/MULHSU/MULHU). One op per
//   cycle, no backpressure. Result appears 3 cycles after issue, or 4 when
//   the optional output register is built.
//   S1: sign/zero-extended 33-bit operands
//   S2: two partial products (low 16 bits of src2 unsigned, upper 17 bits
//       of the extended src2 signed)
//   S3: sum of partial products and lo/hi half select
// Ports
//   clk      : clock, rising edge
//   reset_n  : synchronous active-low reset; clears every stage
//   io       : exunit_mul_pipe_if.slave (issue, branch and result buses)
// Build option
//   MUL_OUT_REG_EN : when defined, adds an output register stage after S3.
//                    kill_spec / rslt_specbit keep their combinational
//                    flush terms on top of that register.
module exunit_mul_pipe #(
  parameter int DATA_LEN    = 32,
  parameter int RRF_SEL     = 6,
  parameter int SPECTAG_LEN = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  exunit_mul_pipe_if.slave io
);
  localparam int XW = DATA_LEN + 1;   // extended operand width
  localparam int HW = DATA_LEN / 2;   // split point of src2
  localparam int PW = 2 * DATA_LEN;   // product bits we keep
`ifdef MUL_OUT_REG_EN
  localparam int NS = 4;
`else
  localparam int NS = 3;
`endif
  localparam int LS = NS - 1;         // stage that drives the outputs

  // Per-stage control metadata, index 0 = S1
  logic [NS-1:0]          valid_reg;
  logic [NS-1:0]          specbit_reg;
  logic [NS-1:0]          dstval_reg;
  logic [SPECTAG_LEN-1:0] spectag_reg [NS];
  logic [RRF_SEL-1:0]     tag_reg     [NS];

  // What each stage would capture before flush/success is applied
  logic [NS-1:0]          up_valid;
  logic [NS-1:0]          up_specbit;
  logic [NS-1:0]          up_dstval;
  logic [SPECTAG_LEN-1:0] up_spectag [NS];
  logic [RRF_SEL-1:0]     up_tag     [NS];
  logic [NS-1:0]          valid_next;
  logic [NS-1:0]          specbit_next;

  // A mispredict in the same cycle overrides a success
  logic branch_ok;
  assign branch_ok = io.prsuccess & ~io.prmiss;

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign up_valid[gi]   = io.issue;
        assign up_specbit[gi] = io.specbit;
        assign up_dstval[gi]  = io.dstval;
        assign up_spectag[gi] = io.spectag;
        assign up_tag[gi]     = io.rrftag;
      end else begin : g_link
        assign up_valid[gi]   = valid_reg[gi-1];
        assign up_specbit[gi] = specbit_reg[gi-1];
        assign up_dstval[gi]  = dstval_reg[gi-1];
        assign up_spectag[gi] = spectag_reg[gi-1];
        assign up_tag[gi]     = tag_reg[gi-1];
      end
      // Only speculative ops can be squashed
      assign valid_next[gi] = up_valid[gi] &
          ~(io.prmiss & up_specbit[gi] & (|(up_spectag[gi] & io.specfixtag)));
      assign specbit_next[gi] = up_specbit[gi] &
          ~(branch_ok & (up_spectag[gi] == io.prtag));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_reg   <= '0;
      specbit_reg <= '0;
      dstval_reg  <= '0;
      for (int i = 0; i < NS; i++) begin
        spectag_reg[i] <= '0;
        tag_reg[i]     <= '0;
      end
    end else begin
      valid_reg   <= valid_next;
      specbit_reg <= specbit_next;
      dstval_reg  <= up_dstval;
      for (int i = 0; i < NS; i++) begin
        spectag_reg[i] <= up_spectag[i];
        tag_reg[i]     <= up_tag[i];
      end
    end
  end

  // Datapath
  logic [XW-1:0]       ext1_reg;
  logic [XW-1:0]       ext2_reg;
  logic                lohi_s1_reg;
  logic                lohi_s2_reg;
  logic [PW-1:0]       p0_reg;
  logic [PW-1:0]       p1_reg;
  logic [DATA_LEN-1:0] rslt_reg;

  logic [PW-1:0]       mul_a;
  logic [PW-1:0]       mul_blo;
  logic [PW-1:0]       mul_bhi;
  logic [PW-1:0]       prod;
  logic [DATA_LEN-1:0] rslt_next;

  // Operands are sign-extended to the full product width so that a plain
  // modulo-2^PW multiply yields the correct two's complement partial sums.
  assign mul_a   = {{(PW-XW){ext1_reg[XW-1]}}, ext1_reg};
  assign mul_blo = {{(PW-HW){1'b0}}, ext2_reg[HW-1:0]};
  assign mul_bhi = {{(PW-XW+HW){ext2_reg[XW-1]}}, ext2_reg[XW-1:HW]};

  assign prod      = p0_reg + (p1_reg << HW);
  assign rslt_next = lohi_s2_reg ? prod[PW-1:DATA_LEN] : prod[DATA_LEN-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ext1_reg    <= '0;
      ext2_reg    <= '0;
      lohi_s1_reg <= 1'b0;
      lohi_s2_reg <= 1'b0;
      p0_reg      <= '0;
      p1_reg      <= '0;
      rslt_reg    <= '0;
    end else begin
      ext1_reg    <= {io.src1_signed & io.src1[DATA_LEN-1], io.src1};
      ext2_reg    <= {io.src2_signed & io.src2[DATA_LEN-1], io.src2};
      lohi_s1_reg <= io.sel_lohi;
      lohi_s2_reg <= lohi_s1_reg;
      p0_reg      <= mul_a * mul_blo;
      p1_reg      <= mul_a * mul_bhi;
      rslt_reg    <= rslt_next;
    end
  end

`ifdef MUL_OUT_REG_EN
  logic [DATA_LEN-1:0] rslt_out_reg;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rslt_out_reg <= '0;
    end else begin
      rslt_out_reg <= rslt_reg;
    end
  end
  assign io.rslt = rslt_out_reg;
`else
  assign io.rslt = rslt_reg;
`endif

  assign io.rslt_valid   = valid_reg[LS];
  assign io.rslt_dst     = tag_reg[LS];
  assign io.rslt_we      = valid_reg[LS] & dstval_reg[LS];
  assign io.busy         = |valid_reg;
  // Same-cycle view of a flush/success on the op currently at the output
  assign io.kill_spec    = valid_reg[LS] & specbit_reg[LS] & io.prmiss &
                           (|(spectag_reg[LS] & io.specfixtag));
  assign io.rslt_specbit = valid_reg[LS] & specbit_reg[LS] &
                           ~(branch_ok & (spectag_reg[LS] == io.prtag));
endmodule
